hs_upload_server: RTL and testbench
===================================

# hs_upload_server

Responder side of the HPS upload channel: serves `ioctl_rd` byte requests from the HPS by fetching bytes out of a core-side RAM port (hiscore/NVRAM region) and returning them on `ioctl_din`. It holds `ioctl_wait` while a fetch is outstanding. It raises `ioctl_upload_req` on a save trigger and pauses the core for the duration of the transfer. It sits in `emu` between `hps_io` and the game core's RAM arbitration, alongside the download path that feeds `dn_addr`/`dn_data`/`dn_wr`.

## Interface
Parameters:
- `AW`, 16: RAM address width.
- `LEN`, 256: number of bytes in the upload image; addresses `>= LEN` are out of range.
- `RAM_LAT`, 1: cycles from the `ram_gnt` cycle to valid `ram_rdata`; legal range 1..3.
- `INDEX`, 8'd4: `ioctl_index` value this block answers to.

Ports:
- `clk_sys`  in  1: system clock.
- `RESET_n`  in  1: synchronous, active-low reset.
- `save_trig`  in  1: one-cycle pulse requesting an upload.
- `ioctl_upload`  in  1: HPS upload session active.
- `ioctl_index`  in  8: current HPS transfer index.
- `ioctl_rd`  in  1: one-cycle read strobe.
- `ioctl_addr`  in  25: byte address of the read.
- `ioctl_din`  out  8: returned byte.
- `ioctl_wait`  out  1: HPS must stall while high.
- `ioctl_upload_req`  out  1: upload request to HPS.
- `ram_req`  out  1: core RAM access request.
- `ram_addr`  out  AW: core RAM address.
- `ram_gnt`  in  1: arbiter grant; meaningful only while `ram_req` is high.
- `ram_rdata`  in  8: core RAM read data.
- `pause_req`  out  1: asks the core pause system to halt the CPU.

## Operation
- A session is `ioctl_upload && ioctl_index==INDEX`. Strobes outside a session are ignored: no state change, `ioctl_wait` stays 0.
- Upload request:
  - `save_trig` sets `ioctl_upload_req`.
  - It clears on the first cycle a session is seen.
  - A `save_trig` that arrives during a session is latched. It re-raises `ioctl_upload_req` the cycle after the session ends.
- `pause_req` = registered (session active OR state != IDLE).
- FSM states: IDLE, REQ, LAT, DONE.
  - **IDLE**, on a session `ioctl_rd` with `ioctl_addr < LEN`:
    - latch `ioctl_addr[AW-1:0]` into `ram_addr`;
    - `ram_req`=1;
    - go to REQ.
  - **IDLE**, on a session `ioctl_rd` with `ioctl_addr >= LEN`: `ioctl_din`<=8'hFF next cycle, no RAM access, stay in IDLE.
  - **REQ**: hold `ram_req`/`ram_addr` stable until `ram_gnt`. In the `ram_gnt` cycle: deassert `ram_req` (registered, low from the next cycle), load the latency counter with `RAM_LAT-1`, go to LAT.
  - **LAT**: count down; at 0 capture `ram_rdata` into `ioctl_din`, go to DONE.
  - **DONE**: drop `ioctl_wait`, go to IDLE.
- `ioctl_wait` = (`ioctl_rd` && session && in-range && state==IDLE) OR (state in {REQ, LAT}).
  - It is combinational on the strobe so that the HPS is stalled in the strobe cycle itself.
  - It is low in DONE.
- A `ioctl_rd` while state != IDLE is a protocol violation by the HPS. It is ignored and must not corrupt the current fetch.
- If the session ends mid-fetch, the fetch completes normally. `ioctl_din` is still updated.
- `ioctl_din` holds its last value between reads.

## Timing
- Reset values (`RESET_n`=0 at a clock edge):
  - state=IDLE;
  - `ioctl_din`=8'h00, `ioctl_wait`=0 (IDLE, no strobe), `ioctl_upload_req`=0, `ram_req`=0, `ram_addr`=0, `pause_req`=0;
  - latched save trigger cleared.
- Reset overrides every other event in the same cycle, including mid-fetch. It abandons any grant in flight.
- In-range read latency, with the strobe at cycle 0 and the grant at cycle g ≥ 1:
  - `ram_req` high from cycle 1 through cycle g;
  - `ioctl_din` valid at cycle g+RAM_LAT+1;
  - `ioctl_wait` high for cycles 0..g+RAM_LAT, low from g+RAM_LAT+1.
  - With an immediate grant (g=1) and RAM_LAT=1, `ioctl_wait` is high for 3 cycles.
- Out-of-range read: `ioctl_din`=FF at cycle 1; `ioctl_wait` never asserted.
- `save_trig` and session start in the same cycle: the request is treated as already satisfied; `ioctl_upload_req` stays 0.
- The address comparison uses the full 25-bit `ioctl_addr`. Upper bits nonzero means out of range.

## Test plan
- Reset: hold `RESET_n`=0 with `ioctl_rd`=1 and `save_trig`=1 asserted -> all outputs 0, no `ram_req`.
- Single read (LEN=256, RAM_LAT=1, `ram_gnt` tied 1):
  - stimulus: rd at addr 0x10, RAM returns 0x5A;
  - response: `ram_addr`=0x10; `ioctl_wait` high exactly 3 cycles; `ioctl_din`=0x5A when wait falls.
- Delayed grant: `ram_gnt` withheld 5 cycles -> `ram_req`/`ram_addr` stable throughout; `ioctl_wait` high 5+RAM_LAT+1 cycles; correct byte returned.
- Boundaries:
  - rd at addr 255 -> RAM fetch;
  - rd at addr 256 and at 0x1000000 -> `ioctl_din`=FF the next cycle, `ioctl_wait` never high, `ram_req` never high.
- Upload request:
  - `save_trig` pulse -> `ioctl_upload_req`=1 until `ioctl_upload` with `ioctl_index`=INDEX; then 0; `pause_req`=1 during the session.
  - Trigger during the session -> request re-raised the cycle after the session ends.
- Robustness:
  - wrong `ioctl_index` with rd -> ignored;
  - second rd during LAT -> ignored, first byte correct;
  - reset asserted in REQ -> IDLE next cycle, `ram_req`=0.

Source files
------------

// File: rtl/hs_upload_server.sv
// hs_upload_server: answers HPS upload reads by fetching bytes from a core RAM port.
// It stalls the HPS with ioctl_wait while a fetch is outstanding, raises
// ioctl_upload_req on a save trigger, and pauses the core during the session.
module hs_upload_server #(
  parameter int          AW      = 16,
  parameter int          LEN     = 256,
  parameter int          RAM_LAT = 1,
  parameter logic [7:0]  INDEX   = 8'd4
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          save_trig,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  output logic          ram_req,
  output logic [AW-1:0] ram_addr,
  input  logic          ram_gnt,
  input  logic [7:0]    ram_rdata,
  output logic          pause_req
);

  typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_t;

  state_t      state, state_nxt;
  logic        session, session_q, in_range, start, save_pend;
  logic [1:0]  lat_cnt;

  assign session  = ioctl_upload && (ioctl_index == INDEX);
  // full 25-bit compare: any nonzero upper bit lands out of range
  assign in_range = ioctl_addr < 25'(LEN);
  assign start    = ioctl_rd && session && in_range && (state == IDLE);

  // State register
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: strobes outside IDLE are ignored so an active fetch is never disturbed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)          state_nxt = REQ;
      REQ:  if (ram_gnt)        state_nxt = LAT;
      LAT:  if (lat_cnt == '0)  state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Stall the HPS in the strobe cycle itself and until the byte is captured
  always_comb begin
    ioctl_wait = RESET_n && (start || (state == REQ) || (state == LAT));
  end

  // Fetch datapath: RAM request/address, latency counter, returned byte
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      lat_cnt   <= '0;
      ioctl_din <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ram_addr <= ioctl_addr[AW-1:0];
            ram_req  <= 1'b1;
          end else if (ioctl_rd && session && !in_range) begin
            ioctl_din <= 8'hFF;
          end
        end
        REQ: begin
          if (ram_gnt) begin
            ram_req <= 1'b0;
            lat_cnt <= 2'(RAM_LAT - 1);
          end
        end
        LAT: begin
          if (lat_cnt == '0) ioctl_din <= ram_rdata;
          else               lat_cnt   <= lat_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Upload request handshake and core pause
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      session_q        <= 1'b0;
      save_pend        <= 1'b0;
      ioctl_upload_req <= 1'b0;
      pause_req        <= 1'b0;
    end else begin
      session_q <= session;
      pause_req <= session || (state != IDLE);
      if (session) begin
        ioctl_upload_req <= 1'b0;
        // a trigger coinciding with session start counts as already served
        if (save_trig && session_q) save_pend <= 1'b1;
      end else begin
        if (save_trig || (session_q && save_pend)) ioctl_upload_req <= 1'b1;
        if (session_q) save_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hs_upload_server.sv
// Directed bench for hs_upload_server (AW=16, LEN=256, RAM_LAT=1, INDEX=4).
// The RAM model returns (addr[7:0] ^ 8'h4A) one cycle after the grant cycle.
module tb_hs_upload_server;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        save_trig;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic        ram_gnt;
  logic [7:0]  ram_rdata;
  logic        pause_req;

  int total = 0;
  int bad   = 0;

  hs_upload_server #(.AW(16), .LEN(256), .RAM_LAT(1), .INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .save_trig(save_trig),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .ram_req(ram_req), .ram_addr(ram_addr),
    .ram_gnt(ram_gnt), .ram_rdata(ram_rdata), .pause_req(pause_req)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM with one cycle of read latency; data is zero except right after a grant
  always @(posedge clk_sys)
    ram_rdata <= (ram_req && ram_gnt) ? (ram_addr[7:0] ^ 8'h4A) : 8'h00;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd4;
    ioctl_rd = 1'b1; ioctl_addr = 25'h10; save_trig = 1'b1; ram_gnt = 1'b1;
    step(); step(); step();
    total++; if (ioctl_din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h exp=00", ioctl_din); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", ioctl_wait); end
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL reset_upreq got=%b exp=0", ioctl_upload_req); end
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL reset_ramreq got=%b exp=0", ram_req); end
    total++; if (ram_addr !== 16'h0) begin bad++; $display("FAIL reset_ramaddr got=%h exp=0000", ram_addr); end
    total++; if (pause_req !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b exp=0", pause_req); end
    ioctl_rd = 1'b0; save_trig = 1'b0; ioctl_upload = 1'b0;
    RESET_n = 1'b1;
    step();
  endtask

  // In-range read with grant first given at cycle g (strobe is cycle 0)
  task automatic do_read(input logic [24:0] a, input int g, input logic [7:0] exp_b,
                         input int exp_w, input string nm);
    int  w;
    bit  done;
    w = 0; done = 1'b0;
    ram_gnt = 1'b0; ioctl_rd = 1'b1; ioctl_addr = a;
    #1;
    if (ioctl_wait) w++;
    step();
    ioctl_rd = 1'b0;
    for (int k = 1; k < 40 && !done; k++) begin
      ram_gnt = (k >= g);
      #1;
      if (k <= g) begin
        total++;
        if (ram_req !== 1'b1 || ram_addr !== a[15:0]) begin
          bad++; $display("FAIL %s_req_hold cyc=%0d got req=%b addr=%h exp req=1 addr=%h", nm, k, ram_req, ram_addr, a[15:0]);
        end
      end else begin
        total++;
        if (ram_req !== 1'b0) begin bad++; $display("FAIL %s_req_drop cyc=%0d got=%b exp=0", nm, k, ram_req); end
      end
      if (ioctl_wait) begin
        w++;
        step();
      end else begin
        done = 1'b1;
        total++; if (ioctl_din !== exp_b) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, ioctl_din, exp_b); end
        total++; if (w !== exp_w) begin bad++; $display("FAIL %s_wait_len got=%0d exp=%0d", nm, w, exp_w); end
      end
    end
    if (!done) begin
      total++; bad++; $display("FAIL %s_timeout got=wait_stuck exp=wait_low", nm);
    end
    ram_gnt = 1'b1;
    step();
  endtask

  task automatic do_oor(input logic [24:0] a, input string nm);
    ioctl_rd = 1'b1; ioctl_addr = a;
    #1;
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL %s_wait0 got=%b exp=0", nm, ioctl_wait); end
    step();
    ioctl_rd = 1'b0;
    #1;
    total++; if (ioctl_din !== 8'hFF) begin bad++; $display("FAIL %s_din got=%h exp=ff", nm, ioctl_din); end
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL %s_req1 got=%b exp=0", nm, ram_req); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL %s_wait1 got=%b exp=0", nm, ioctl_wait); end
    step();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL %s_req2 got=%b exp=0", nm, ram_req); end
  endtask

  task automatic test_single_read();
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    step();
    do_read(25'h10, 1, 8'h5A, 3, "single");
  endtask

  task automatic test_delayed_grant();
    do_read(25'h20, 5, 8'h6A, 7, "delayed");
  endtask

  task automatic test_boundaries();
    do_oor(25'd256, "oor256");
    do_read(25'd255, 1, 8'hB5, 3, "addr255");
    do_oor(25'h1000000, "oor_hi");
  endtask

  task automatic test_wrong_index();
    ioctl_index = 8'd3; ioctl_rd = 1'b1; ioctl_addr = 25'h20;
    #1;
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL wrongidx_wait got=%b exp=0", ioctl_wait); end
    step();
    ioctl_rd = 1'b0;
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL wrongidx_req got=%b exp=0", ram_req); end
    total++; if (ioctl_din !== 8'hFF) begin bad++; $display("FAIL wrongidx_din got=%h exp=ff", ioctl_din); end
    step();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL wrongidx_req2 got=%b exp=0", ram_req); end
    ioctl_index = 8'd4;
    step();
  endtask

  task automatic test_back_to_back();
    ram_gnt = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'h40;
    #1;
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL b2b_wait0 got=%b exp=1", ioctl_wait); end
    step();
    ioctl_rd = 1'b0;
    step();
    ioctl_rd = 1'b1; ioctl_addr = 25'h30;
    #1;
    total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL b2b_wait_lat got=%b exp=1", ioctl_wait); end
    step();
    ioctl_rd = 1'b0;
    #1;
    total++; if (ioctl_din !== 8'h0A) begin bad++; $display("FAIL b2b_data got=%h exp=0a", ioctl_din); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL b2b_wait_done got=%b exp=0", ioctl_wait); end
    step();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL b2b_no_refetch got=%b exp=0", ram_req); end
    total++; if (ram_addr !== 16'h0040) begin bad++; $display("FAIL b2b_addr got=%h exp=0040", ram_addr); end
  endtask

  task automatic test_reset_in_req();
    ram_gnt = 1'b0; ioctl_rd = 1'b1; ioctl_addr = 25'h50;
    step();
    ioctl_rd = 1'b0;
    #1;
    total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL rstreq_pre got=%b exp=1", ram_req); end
    RESET_n = 1'b0;
    step();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL rstreq_req got=%b exp=0", ram_req); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rstreq_wait got=%b exp=0", ioctl_wait); end
    RESET_n = 1'b1; ram_gnt = 1'b1;
    step();
    total++; if (ram_req !== 1'b0 || ioctl_wait !== 1'b0) begin
      bad++; $display("FAIL rstreq_idle got req=%b wait=%b exp req=0 wait=0", ram_req, ioctl_wait);
    end
  endtask

  task automatic test_upload_req();
    ioctl_upload = 1'b0;
    step(); step();
    total++; if (pause_req !== 1'b0) begin bad++; $display("FAIL up_pause_idle got=%b exp=0", pause_req); end
    save_trig = 1'b1;
    step();
    save_trig = 1'b0;
    total++; if (ioctl_upload_req !== 1'b1) begin bad++; $display("FAIL up_set got=%b exp=1", ioctl_upload_req); end
    step(); step();
    total++; if (ioctl_upload_req !== 1'b1) begin bad++; $display("FAIL up_hold got=%b exp=1", ioctl_upload_req); end
    ioctl_upload = 1'b1;
    step();
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL up_clear got=%b exp=0", ioctl_upload_req); end
    total++; if (pause_req !== 1'b1) begin bad++; $display("FAIL up_pause got=%b exp=1", pause_req); end
    save_trig = 1'b1;
    step();
    save_trig = 1'b0;
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL up_in_session got=%b exp=0", ioctl_upload_req); end
    ioctl_upload = 1'b0;
    #1;
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL up_end_cyc got=%b exp=0", ioctl_upload_req); end
    step();
    total++; if (ioctl_upload_req !== 1'b1) begin bad++; $display("FAIL up_reraise got=%b exp=1", ioctl_upload_req); end
    total++; if (pause_req !== 1'b0) begin bad++; $display("FAIL up_pause_end got=%b exp=0", pause_req); end
    ioctl_upload = 1'b1; save_trig = 1'b1;
    step();
    save_trig = 1'b0;
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL up_same_cyc got=%b exp=0", ioctl_upload_req); end
    step();
    ioctl_upload = 1'b0;
    step(); step();
    total++; if (ioctl_upload_req !== 1'b0) begin bad++; $display("FAIL up_no_reraise got=%b exp=0", ioctl_upload_req); end
  endtask

  initial begin
    RESET_n = 1'b0; save_trig = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; ram_gnt = 1'b1;
    step();
    test_reset();
    test_single_read();
    test_delayed_grant();
    test_boundaries();
    test_wrong_index();
    test_back_to_back();
    test_reset_in_req();
    test_upload_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
